// File: rtl/avmm_mem_pkg.sv
// Shared widths, clear-engine state encoding and the byte-lane mask helper
// for the Avalon-MM memory responder.
package avmm_mem_pkg;

  localparam int unsigned AVMM_DATA_W = 64;
  localparam int unsigned AVMM_ADDR_W = 64;
  localparam int unsigned AVMM_BE_W   = 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  // Expands a per-byte enable into a full-width bit mask.
  function automatic logic [AVMM_DATA_W-1:0] be_mask(input logic [AVMM_BE_W-1:0] be);
    logic [AVMM_DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < AVMM_BE_W; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read-return pipeline; each data stage only loads when its
// incoming valid is set, so the output holds the last returned word.
module avmm_rd_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      if (in_valid_i) begin
        data_q[0] <= in_data_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave word memory with byte-enable writes, fixed-latency reads,
// a host side port and a whole-memory clear engine.
module avmm_mem_responder
  import avmm_mem_pkg::*;
#(
  parameter int unsigned            DEPTH_LOG2   = 10,
  parameter int unsigned            READ_LATENCY = 2,
  parameter logic [AVMM_ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [AVMM_ADDR_W-1:0] avs_address,
  input  logic [AVMM_BE_W-1:0]   avs_byteenable,
  input  logic                   avs_read,
  output logic [AVMM_DATA_W-1:0] avs_readdata,
  output logic                   avs_readdatavalid,
  input  logic                   avs_write,
  input  logic [AVMM_DATA_W-1:0] avs_writedata,
  input  logic [DEPTH_LOG2-1:0]  host_addr,
  input  logic                   host_we,
  input  logic [AVMM_DATA_W-1:0] host_wdata,
  output logic [AVMM_DATA_W-1:0] host_rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   err_range,
  output logic                   err_proto,
  input  logic                   err_clr
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [AVMM_DATA_W-1:0] mem_q [Depth];
  logic [AVMM_DATA_W-1:0] host_rdata_q;
  clr_state_e             state_q;
  logic [DEPTH_LOG2-1:0]  clr_cnt_q;
  logic                   clear_busy_q;
  logic                   err_range_q, err_proto_q;

  logic [AVMM_ADDR_W-1:0] off;
  logic                   addr_ok;
  logic [DEPTH_LOG2-1:0]  avs_idx;
  logic                   clearing, rd_only, wr_only;
  logic                   avs_we, host_wr, set_range, set_proto;
  logic [AVMM_DATA_W-1:0] mask, wr_base, wr_word, rd_word;

  assign off      = avs_address - BASE_ADDR;
  assign addr_ok  = (off[2:0] == 3'b000) && (off[AVMM_ADDR_W-1:DEPTH_LOG2+3] == '0);
  assign avs_idx  = off[DEPTH_LOG2+2:3];
  assign clearing = (state_q == StClear);
  assign rd_only  = avs_read & ~avs_write;
  assign wr_only  = avs_write & ~avs_read;
  assign avs_we   = wr_only & addr_ok & ~clearing;
  assign host_wr  = host_we & ~clearing;

  // A same-word host write supplies the bytes the avs write leaves disabled.
  assign mask    = be_mask(avs_byteenable);
  assign wr_base = (host_wr && (host_addr == avs_idx)) ? host_wdata : mem_q[avs_idx];
  assign wr_word = (avs_writedata & mask) | (wr_base & ~mask);
  assign rd_word = (addr_ok && !clearing) ? mem_q[avs_idx] : '0;

  assign set_range = (rd_only | wr_only) & ~addr_ok;
  assign set_proto = (avs_read & avs_write) | (clearing & (avs_read | avs_write));

  always_ff @(posedge clock) begin
    if (clearing) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (host_wr) begin
        mem_q[host_addr] <= host_wdata;
      end
      if (avs_we) begin
        mem_q[avs_idx] <= wr_word;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      host_rdata_q <= '0;
      err_range_q  <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      host_rdata_q <= mem_q[host_addr];
      err_range_q  <= set_range | (err_range_q & ~err_clr);
      err_proto_q  <= set_proto | (err_proto_q & ~err_clr);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        StClear: begin
          if (clr_cnt_q == '1) begin
            state_q      <= StIdle;
            clear_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= StIdle;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  avmm_rd_pipe #(
    .LATENCY(READ_LATENCY),
    .DATA_W (AVMM_DATA_W)
  ) u_rd_pipe (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .in_valid_i (rd_only),
    .in_data_i  (rd_word),
    .out_valid_o(avs_readdatavalid),
    .out_data_o (avs_readdata)
  );

  assign host_rdata = host_rdata_q;
  assign clear_busy = clear_busy_q;
  assign err_range  = err_range_q;
  assign err_proto  = err_proto_q;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Randomised and directed bench with a queue scoreboard for read returns and
// an array reference model of the memory, errors and clear engine.
module tb_avmm_mem_responder;

  localparam int unsigned DEPTH_LOG2   = 10;
  localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
  localparam int unsigned READ_LATENCY = 2;
  localparam logic [63:0] BASE_ADDR    = 64'h0;

  logic                  clock;
  logic                  resetn;
  logic [63:0]           avs_address;
  logic [7:0]            avs_byteenable;
  logic                  avs_read;
  logic [63:0]           avs_readdata;
  logic                  avs_readdatavalid;
  logic                  avs_write;
  logic [63:0]           avs_writedata;
  logic [DEPTH_LOG2-1:0] host_addr;
  logic                  host_we;
  logic [63:0]           host_wdata;
  logic [63:0]           host_rdata;
  logic                  clear_start;
  logic                  clear_busy;
  logic                  err_range;
  logic                  err_proto;
  logic                  err_clr;

  avmm_mem_responder #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .READ_LATENCY(READ_LATENCY),
    .BASE_ADDR   (BASE_ADDR)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .avs_address      (avs_address),
    .avs_byteenable   (avs_byteenable),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .host_addr        (host_addr),
    .host_we          (host_we),
    .host_wdata       (host_wdata),
    .host_rdata       (host_rdata),
    .clear_start      (clear_start),
    .clear_busy       (clear_busy),
    .err_range        (err_range),
    .err_proto        (err_proto),
    .err_clr          (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] model [DEPTH];
  logic [63:0] last_rd;
  int          cyc;
  int          n_checks;
  int          n_err;
  int          m_clear_left;
  bit          m_err_range;
  bit          m_err_proto;
  bit          host_chk_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: every valid pulse pops one expected return; otherwise data must hold.
  always @(negedge clock) begin
    if (resetn) begin
      if (avs_readdatavalid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("rd_data", avs_readdata, mon_e.data);
          chk("rd_latency", 64'(cyc), 64'(mon_e.cyc));
          last_rd = mon_e.data;
        end
      end else begin
        chk("rd_hold", avs_readdata, last_rd);
      end
    end
  end

  // One clock of stimulus; the model applies the same cycle's effects.
  task automatic step(input bit rd, input bit wr, input logic [63:0] addr,
                      input logic [7:0] be, input logic [63:0] wd, input bit hwe,
                      input int unsigned haddr, input logic [63:0] hwd,
                      input bit cs, input bit ec);
    logic [63:0] off;
    logic [63:0] exp_h;
    bit          legal, pre, s_rng, s_pro;
    int unsigned idx;
    exp_t        e;
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = addr;
    avs_byteenable = be;
    avs_writedata  = wd;
    host_we        = hwe;
    host_addr      = DEPTH_LOG2'(haddr);
    host_wdata     = hwd;
    clear_start    = cs;
    err_clr        = ec;
    pre   = (m_clear_left > 0);
    off   = addr - BASE_ADDR;
    legal = (off % 8 == 0) && ((off / 8) < 64'(DEPTH));
    idx   = legal ? int'(off / 8) : 0;
    if (rd && !wr) begin
      e.data = (legal && !pre) ? model[idx] : 64'h0;
      e.cyc  = cyc + int'(READ_LATENCY);
      q.push_back(e);
    end
    exp_h = model[haddr];
    s_rng = (rd != wr) && !legal;
    s_pro = (rd && wr) || (pre && (rd || wr));
    @(posedge clock);
    #1;
    if (!pre) begin
      if (hwe) model[haddr] = hwd;
      if (wr && !rd && legal) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (cs) m_clear_left = DEPTH;
    end else begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) model[i] = 64'h0;
      end
    end
    m_err_range = s_rng || (m_err_range && !ec);
    m_err_proto = s_pro || (m_err_proto && !ec);
    chk("err_range", 64'(err_range), 64'(m_err_range));
    chk("err_proto", 64'(err_proto), 64'(m_err_proto));
    chk("clear_busy", 64'(clear_busy), 64'(m_clear_left > 0));
    if (host_chk_en && !pre) chk("host_rdata", host_rdata, exp_h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 64'h0, 0, 0);
  endtask

  task automatic avs_rd(input logic [63:0] a);
    step(1, 0, a, 8'h0, 64'h0, 0, 0, 64'h0, 0, 0);
  endtask

  initial begin
    logic [63:0] a, d;
    int unsigned w, hw, sel, busy_cnt, n;
    bit          rd, wr, hwe;
    n_checks = 0; n_err = 0; cyc = 0; last_rd = 64'h0;
    m_clear_left = 0; m_err_range = 0; m_err_proto = 0; host_chk_en = 0;
    avs_read = 0; avs_write = 0; avs_address = 0; avs_byteenable = 0; avs_writedata = 0;
    host_we = 0; host_addr = 0; host_wdata = 0; clear_start = 0; err_clr = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_readdata", avs_readdata, 64'h0);
    chk("reset_valid", 64'(avs_readdatavalid), 64'h0);
    chk("reset_host_rdata", host_rdata, 64'h0);
    chk("reset_busy", 64'(clear_busy), 64'h0);
    chk("reset_errs", 64'({err_range, err_proto}), 64'h0);
    resetn = 1'b1;

    // Preload every word so the model is fully known.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 64'h0, 8'h0, 64'h0, 1, i, {$urandom, $urandom}, 0, 0);
    host_chk_en = 1;

    // Directed: host preload, read back over avs, partial byte write.
    step(0, 0, 64'h0, 8'h0, 64'h0, 1, 3, 64'h1122334455667788, 0, 0);
    avs_rd(64'h18);
    idle(3);
    step(0, 1, 64'h18, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 64'h0, 0, 0);
    step(0, 0, 64'h0, 8'h0, 64'h0, 0, 3, 64'h0, 0, 0);
    chk("byte_merge", host_rdata, 64'h11223344FFFFFFFF);
    avs_rd(64'h0); avs_rd(64'h8); avs_rd(64'h10);
    idle(3);

    // Misaligned and out-of-range reads return zero and set the sticky error.
    avs_rd(64'h2004); avs_rd(64'h2000);
    idle(4);
    chk("err_range_sticky", 64'(err_range), 64'h1);
    step(0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 64'h0, 0, 1);
    chk("err_range_cleared", 64'(err_range), 64'h0);

    // Same-cycle avs and host writes to one word, and read vs host write.
    step(0, 1, 64'h28, 8'hA5, 64'hAAAA_BBBB_CCCC_DDDD, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0);
    step(1, 0, 64'h28, 8'h0, 64'h0, 1, 5, 64'h5555_6666_7777_8888, 0, 0);
    avs_rd(64'h28);
    idle(3);

    // Random mix over a small window so accesses collide often.
    for (int i = 0; i < 400; i++) begin
      w   = $urandom_range(0, 15);
      a   = 64'(w) << 3;
      sel = $urandom_range(0, 15);
      if (sel == 0) a = a | 64'($urandom_range(1, 7));
      else if (sel == 1) a = 64'h2000 + a;
      sel = $urandom_range(0, 7);
      rd  = (sel <= 2) || (sel == 6);
      wr  = (sel >= 3 && sel <= 6);
      hwe = ($urandom_range(0, 2) == 0);
      hw  = $urandom_range(0, 15);
      d   = {$urandom, $urandom};
      step(rd, wr, a, 8'($urandom), d, hwe, hw, {$urandom, $urandom}, 0,
           $urandom_range(0, 9) == 0);
    end
    idle(3);

    // Clear engine: busy length, dropped write mid-clear, full readback.
    step(0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 64'h0, 1, 1);
    busy_cnt = clear_busy ? 1 : 0;
    n = 0;
    while (clear_busy === 1'b1 && n < 1100) begin
      if (n == 500) step(0, 1, 64'h40, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1, 9, 64'h1, 1, 0);
      else idle(1);
      if (clear_busy) busy_cnt++;
      n++;
    end
    chk("clear_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
    chk("clear_proto_err", 64'(err_proto), 64'h1);
    for (int i = 0; i < DEPTH; i++) avs_rd(64'(i) << 3);
    idle(4);

    // Simultaneous read and write: ignored, no return, memory untouched.
    step(0, 1, 64'h30, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 64'h0, 0, 1);
    step(1, 1, 64'h30, 8'hFF, 64'hFFFF_0000_FFFF_0000, 0, 0, 64'h0, 0, 0);
    chk("proto_err", 64'(err_proto), 64'h1);
    idle(3);
    avs_rd(64'h30);
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'h0);

    // Reset mid-clear with reads in flight.
    step(0, 0, 64'h0, 8'h0, 64'h0, 0, 0, 64'h0, 1, 0);
    idle(5);
    avs_rd(64'h0); avs_rd(64'h8);
    resetn = 1'b0;
    last_rd = 64'h0;
    q.delete();
    host_chk_en = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(clear_busy), 64'h0);
    chk("rst_valid", 64'(avs_readdatavalid), 64'h0);
    chk("rst_errs", 64'({err_range, err_proto}), 64'h0);
    resetn = 1'b1;
    avs_read = 0; clear_start = 0;
    repeat (8) @(posedge clock);
    #1;
    chk("rst_busy_after", 64'(clear_busy), 64'h0);
    chk("rst_readdata", avs_readdata, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
